// File: rtl/pack6_decoder.sv
// Decoder for 6-bit packed words, with a single-entry valid/ready output register.
// Define PACK6_ERRCNT_EN to add the saturating err_count port and counter.
module pack6_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_hi_pair,
    output logic       out_b1,
    output logic       out_b1_known,
    output logic       out_lsb,
    output logic       out_err,
    output logic [7:0] word_count
`ifdef PACK6_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       w_accept;
    logic       w_hi_pair;
    logic       w_b1;
    logic       w_b1_known;
    logic       w_lsb;
    logic       w_err;
    logic       r_hi_pair;
    logic       r_b1;
    logic       r_b1_known;
    logic       r_lsb;
    logic       r_err;
    logic [7:0] r_word_count;

    assign in_ready = (r_state == StEmpty) || out_ready;
    assign w_accept = in_valid && in_ready;

    // With the AND flag set, bit 1 of the original nibble cannot be recovered.
    always_comb begin
        w_hi_pair  = in_data[5];
        w_lsb      = in_data[3];
        w_b1       = in_data[5] ? 1'b0 : in_data[4];
        w_b1_known = ~in_data[5];
        w_err      = (|in_data[2:0]) || (in_data[5] && !in_data[4]);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_accept) w_state_next = StFull;
            StFull:  if (!w_accept && out_ready) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_pair  <= 1'b0;
            r_b1       <= 1'b0;
            r_b1_known <= 1'b0;
            r_lsb      <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_hi_pair  <= w_hi_pair;
            r_b1       <= w_b1;
            r_b1_known <= w_b1_known;
            r_lsb      <= w_lsb;
            r_err      <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= 8'd0;
        end else if (w_accept && (r_word_count != 8'hFF)) begin
            r_word_count <= r_word_count + 8'd1;
        end
    end

`ifdef PACK6_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_accept && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign out_valid    = (r_state == StFull);
    assign out_hi_pair  = r_hi_pair;
    assign out_b1       = r_b1;
    assign out_b1_known = r_b1_known;
    assign out_lsb      = r_lsb;
    assign out_err      = r_err;
    assign word_count   = r_word_count;

endmodule

// File: doc/pack6_decoder.md
PACK6_DECODER -- requirements
Module: pack6_decoder

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have `in_valid`, input, 1 bit: the upstream word on `in_data` is valid.
REQ-004 The block SHALL have `in_data`, input, 6 bits: the packed word. Bit 5 = AND flag, bit 4 = OR flag, bit 3 = LSB field, bits 2:0 = ZERO pad.
REQ-005 The block SHALL have `in_ready`, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have `out_valid`, output, 1 bit: the decoded result is held on the outputs.
REQ-007 The block SHALL have `out_ready`, input, 1 bit: downstream consumes the result this cycle.
REQ-008 The block SHALL have `out_hi_pair`, output, 1 bit: the recovered original bits [3:2] were both 1.
REQ-009 The block SHALL have `out_b1`, output, 1 bit: the recovered original bit 1.
REQ-010 The block SHALL have `out_b1_known`, output, 1 bit: `out_b1` is determinate.
REQ-011 The block SHALL have `out_lsb`, output, 1 bit: the recovered original bit 0.
REQ-012 The block SHALL have `out_err`, output, 1 bit: the held word violated the packing rules.
REQ-013 The block SHALL have `word_count`, output, 8 bits: the number of accepted words, saturating.
REQ-014 The block SHALL have `err_count`, output, 8 bits: the number of accepted erroneous words, saturating; present only under `PACK6_ERRCNT_EN`.

Function
REQ-015 The block SHALL implement a two-state FSM. State EMPTY has `out_valid`=0. State FULL has `out_valid`=1.
REQ-016 The block SHALL drive `in_ready` = (state==EMPTY) OR `out_ready`, which gives one word per cycle under continuous flow.
REQ-017 The block SHALL accept a word on a clock edge where `in_valid` and `in_ready` are both 1; the decoded result SHALL appear registered on the next cycle (latency 1).
REQ-018 Transitions: EMPTY->FULL on accept. FULL->EMPTY on `out_ready` with no accept. FULL stays FULL on simultaneous `out_ready` and accept, with the outputs replaced by the new word.
REQ-019 In FULL with `out_ready`=0, all result outputs SHALL hold stable and `in_ready` SHALL be 0.
REQ-020 Decode: `out_hi_pair` = bit5; `out_lsb` = bit3.
REQ-021 Decode when bit5=0: `out_b1` = bit4 and `out_b1_known` = 1.
REQ-022 Decode when bit5=1: `out_b1` = 0 and `out_b1_known` = 0.
REQ-023 `out_err` SHALL be 1 when bits[2:0] != 000, or when bit5=1 and bit4=0; error words SHALL still be presented, with decode applied.
REQ-024 `word_count` SHALL increment on every accept and saturate at 255.
REQ-025 `err_count` SHALL increment on every accept with a detected error and saturate at 255.
REQ-026 While in EMPTY, the result outputs SHALL hold their last values; consumers SHALL qualify them with `out_valid`.

Reset
REQ-027 Asserting `rst_n`=0 SHALL immediately, without a clock, force state EMPTY and drive `out_valid`=0, all result outputs 0, `word_count`=0 and `err_count`=0.
REQ-028 Reset asserted while FULL SHALL discard the held word; it SHALL NOT be counted again or presented after release.
REQ-029 The first accept SHALL occur no earlier than the first rising edge after `rst_n` deasserts.

Configuration
REQ-030 With `PACK6_ERRCNT_EN` defined, the block SHALL include the `err_count` port and its counter.
REQ-031 Without `PACK6_ERRCNT_EN`, the block SHALL omit the `err_count` port and counter; `out_err` SHALL still be produced.

Verification
REQ-032 Scenario -- valid AND word: in_data=6'b110000 (packed from 4'hC) accepted -> next cycle out_valid=1, out_hi_pair=1, out_b1_known=0, out_b1=0, out_lsb=0, out_err=0.
REQ-033 Scenario -- valid OR/LSB word: in_data=6'b011000 -> out_hi_pair=0, out_b1=1, out_b1_known=1, out_lsb=1, out_err=0.
REQ-034 Scenario -- rule violations: in_data=6'b100000, then 6'b000101 -> out_err=1 for each; err_count=2 and word_count=2.
REQ-035 Scenario -- backpressure: out_ready=0 for 3 cycles after an accept -> in_ready=0 and outputs stable; out_ready=1 together with a new in_valid -> replacement occurs in the same cycle.
REQ-036 Scenario -- saturation: 300 consecutive accepts of 6'b000001 -> word_count=255 and err_count=255.
REQ-037 Scenario -- reset mid-operation: rst_n=0 while FULL -> out_valid and counters are 0 asynchronously, before the next clock edge.
